fu_issue_arbiter: RTL and testbench

- Shares one non-pipelined, variable-latency functional unit among NUM_REQ issue sources (reservation-station ports) using round-robin arbitration.
- Sequences each instruction to the FU: latch, issue, wait for result.
- Holds the FU result in a one-entry buffer until the writeback/CDB port accepts it.
- Supports pipeline flush and a response timeout.

---
 rtl/fu_issue_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_fu_issue_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_arbiter.sv
// rtl/fu_issue_arbiter.sv - round-robin issue arbiter sharing one variable-latency FU
// Grants one requester at a time, issues to the FU, and buffers the result for writeback.

module fu_issue_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int INST_ID_BITS   = 6,
  parameter int PRN_BITS       = 6,
  parameter int MAX_OPERANDS   = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_flush,
  input  logic [NUM_REQ-1:0]                        i_req_valid,
  output logic [NUM_REQ-1:0]                        o_req_ready,
  input  logic [NUM_REQ*INST_ID_BITS-1:0]           i_req_inst_id,
  input  logic [NUM_REQ*32-1:0]                     i_req_inst,
  input  logic [NUM_REQ*MAX_OPERANDS*64-1:0]        i_req_op,
  input  logic [NUM_REQ*MAX_OPERANDS*PRN_BITS-1:0]  i_req_out_prn,
  input  logic [NUM_REQ*64-1:0]                     i_req_pc,
  output logic [INST_ID_BITS-1:0]                   o_fu_inst_id,
  output logic [31:0]                               o_fu_inst,
  output logic [MAX_OPERANDS*64-1:0]                o_fu_op,
  output logic [MAX_OPERANDS*PRN_BITS-1:0]          o_fu_out_prn,
  output logic [63:0]                               o_fu_pc,
  output logic                                      o_fu_inst_valid,
  input  logic                                      i_fu_out_valid,
  input  logic [INST_ID_BITS-1:0]                   i_fu_out_inst_id,
  input  logic [MAX_OPERANDS*PRN_BITS-1:0]          i_fu_out_prn,
  input  logic [MAX_OPERANDS*64-1:0]                i_fu_out_data,
  input  logic [MAX_OPERANDS-1:0]                   i_fu_out_vld,
  output logic                                      o_wb_valid,
  input  logic                                      i_wb_ready,
  output logic [INST_ID_BITS-1:0]                   o_wb_inst_id,
  output logic [MAX_OPERANDS*PRN_BITS-1:0]          o_wb_prn,
  output logic [MAX_OPERANDS*64-1:0]                o_wb_data,
  output logic [MAX_OPERANDS-1:0]                   o_wb_vld,
  output logic                                      o_err_timeout,
  output logic                                      o_err_id_mismatch
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int OP_W   = MAX_OPERANDS * 64;
  localparam int PRNV_W = MAX_OPERANDS * PRN_BITS;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]              r_state;
  logic [PTR_W-1:0]        r_rr_ptr;
  logic [TMR_W-1:0]        r_timer;
  logic [INST_ID_BITS-1:0] r_fu_inst_id;
  logic [31:0]             r_fu_inst;
  logic [OP_W-1:0]         r_fu_op;
  logic [PRNV_W-1:0]       r_fu_out_prn;
  logic [63:0]             r_fu_pc;
  logic                    r_fu_inst_valid;
  logic                    r_wb_valid;
  logic [INST_ID_BITS-1:0] r_wb_inst_id;
  logic [PRNV_W-1:0]       r_wb_prn;
  logic [OP_W-1:0]         r_wb_data;
  logic [MAX_OPERANDS-1:0] r_wb_vld;
  logic                    r_err_timeout;
  logic                    r_err_id_mismatch;

  logic [PTR_W-1:0]        w_grant;
  logic [PTR_W-1:0]        w_scan;
  logic                    w_grant_found;
  logic                    w_accept;
  logic [NUM_REQ-1:0]      w_req_ready;
  logic                    w_id_match;
  logic                    w_timer_done;

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant       = '0;
    w_scan        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_scan = PTR_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (i_req_valid[w_scan]) begin
        w_grant_found = 1'b1;
        w_grant       = w_scan;
      end
    end
  end

  assign w_accept     = (r_state == S_IDLE) && !i_flush && w_grant_found;
  assign w_id_match   = (i_fu_out_inst_id == r_fu_inst_id);
  assign w_timer_done = (r_timer == TMR_MAX);

  always_comb begin
    w_req_ready = '0;
    if (w_accept) begin
      w_req_ready[w_grant] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= S_IDLE;
      r_rr_ptr          <= '0;
      r_timer           <= '0;
      r_fu_inst_id      <= '0;
      r_fu_inst         <= '0;
      r_fu_op           <= '0;
      r_fu_out_prn      <= '0;
      r_fu_pc           <= '0;
      r_fu_inst_valid   <= 1'b0;
      r_wb_valid        <= 1'b0;
      r_wb_inst_id      <= '0;
      r_wb_prn          <= '0;
      r_wb_data         <= '0;
      r_wb_vld          <= '0;
      r_err_timeout     <= 1'b0;
      r_err_id_mismatch <= 1'b0;
    end else begin
      r_fu_inst_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_fu_out_valid) begin
            r_err_id_mismatch <= 1'b1;
          end
          if (w_accept) begin
            r_fu_inst_id    <= i_req_inst_id[w_grant*INST_ID_BITS +: INST_ID_BITS];
            r_fu_inst       <= i_req_inst[w_grant*32 +: 32];
            r_fu_op         <= i_req_op[w_grant*OP_W +: OP_W];
            r_fu_out_prn    <= i_req_out_prn[w_grant*PRNV_W +: PRNV_W];
            r_fu_pc         <= i_req_pc[w_grant*64 +: 64];
            r_fu_inst_valid <= 1'b1;
            r_rr_ptr        <= PTR_W'((int'(w_grant) + 1) % NUM_REQ);
            r_timer         <= '0;
            r_state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response arriving with the flush has already left the FU, so nothing remains to drain.
          if (i_flush) begin
            r_timer <= '0;
            r_state <= i_fu_out_valid ? S_IDLE : S_DRAIN;
          end else if (i_fu_out_valid && w_id_match) begin
            r_wb_inst_id <= i_fu_out_inst_id;
            r_wb_prn     <= i_fu_out_prn;
            r_wb_data    <= i_fu_out_data;
            r_wb_vld     <= i_fu_out_vld;
            r_wb_valid   <= 1'b1;
            r_state      <= S_HOLD;
          end else begin
            if (i_fu_out_valid) begin
              r_err_id_mismatch <= 1'b1;
            end
            if (w_timer_done) begin
              r_err_timeout <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_timer <= r_timer + TMR_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (i_fu_out_valid) begin
            r_err_id_mismatch <= 1'b1;
          end
          if (i_flush || i_wb_ready) begin
            r_wb_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (i_fu_out_valid) begin
            r_state <= S_IDLE;
          end else if (w_timer_done) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready       = w_req_ready;
  assign o_fu_inst_id      = r_fu_inst_id;
  assign o_fu_inst         = r_fu_inst;
  assign o_fu_op           = r_fu_op;
  assign o_fu_out_prn      = r_fu_out_prn;
  assign o_fu_pc           = r_fu_pc;
  assign o_fu_inst_valid   = r_fu_inst_valid;
  assign o_wb_valid        = r_wb_valid;
  assign o_wb_inst_id      = r_wb_inst_id;
  assign o_wb_prn          = r_wb_prn;
  assign o_wb_data         = r_wb_data;
  assign o_wb_vld          = r_wb_vld;
  assign o_err_timeout     = r_err_timeout;
  assign o_err_id_mismatch = r_err_id_mismatch;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb/tb_fu_issue_arbiter.sv - scenario tasks plus a randomized run against a transaction-level model

module tb_fu_issue_arbiter;
  localparam int NR = 4;
  localparam int IB = 6;
  localparam int PB = 6;
  localparam int MO = 3;
  localparam int TO = 8;

  logic clk, rst, flush;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*IB-1:0] req_inst_id;
  logic [NR*32-1:0] req_inst;
  logic [NR*MO*64-1:0] req_op;
  logic [NR*MO*PB-1:0] req_out_prn;
  logic [NR*64-1:0] req_pc;
  logic [IB-1:0] fu_inst_id;
  logic [31:0] fu_inst;
  logic [MO*64-1:0] fu_op;
  logic [MO*PB-1:0] fu_out_prn_o;
  logic [63:0] fu_pc;
  logic fu_inst_valid;
  logic fu_out_valid;
  logic [IB-1:0] fu_out_inst_id;
  logic [MO*PB-1:0] fu_out_prn;
  logic [MO*64-1:0] fu_out_data;
  logic [MO-1:0] fu_out_vld;
  logic wb_valid, wb_ready;
  logic [IB-1:0] wb_inst_id;
  logic [MO*PB-1:0] wb_prn;
  logic [MO*64-1:0] wb_data;
  logic [MO-1:0] wb_vld;
  logic err_timeout, err_id_mismatch;

  int n_checks = 0;
  int n_fail = 0;

  logic [IB-1:0] m_id[NR];
  logic [31:0] m_inst[NR];
  logic [MO*64-1:0] m_op[NR];
  logic [MO*PB-1:0] m_prn[NR];
  logic [63:0] m_pc[NR];

  bit fu_auto, fu_lat_rand, fu_resp_now;
  int fu_lat, fu_cnt;
  logic [IB-1:0] fu_id;
  logic [MO*64-1:0] resp_data;
  logic [MO-1:0] resp_vld;
  logic [MO*PB-1:0] resp_prn;

  fu_issue_arbiter #(.NUM_REQ(NR), .INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_inst_id(req_inst_id), .i_req_inst(req_inst), .i_req_op(req_op),
    .i_req_out_prn(req_out_prn), .i_req_pc(req_pc),
    .o_fu_inst_id(fu_inst_id), .o_fu_inst(fu_inst), .o_fu_op(fu_op),
    .o_fu_out_prn(fu_out_prn_o), .o_fu_pc(fu_pc), .o_fu_inst_valid(fu_inst_valid),
    .i_fu_out_valid(fu_out_valid), .i_fu_out_inst_id(fu_out_inst_id),
    .i_fu_out_prn(fu_out_prn), .i_fu_out_data(fu_out_data), .i_fu_out_vld(fu_out_vld),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_inst_id(wb_inst_id),
    .o_wb_prn(wb_prn), .o_wb_data(wb_data), .o_wb_vld(wb_vld),
    .o_err_timeout(err_timeout), .o_err_id_mismatch(err_id_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [MO*64-1:0] rnd_op();
    logic [MO*64-1:0] v;
    for (int k = 0; k < MO * 2; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic rand_req(input int r, input logic [IB-1:0] id);
    m_id[r]   = id;
    m_inst[r] = $urandom;
    m_op[r]   = rnd_op();
    m_prn[r]  = (MO*PB)'({$urandom, $urandom});
    m_pc[r]   = {$urandom, $urandom};
    req_inst_id[r*IB +: IB]        = m_id[r];
    req_inst[r*32 +: 32]           = m_inst[r];
    req_op[r*MO*64 +: MO*64]       = m_op[r];
    req_out_prn[r*MO*PB +: MO*PB]  = m_prn[r];
    req_pc[r*64 +: 64]             = m_pc[r];
  endtask

  // Advance one clock and land 1ns after the edge; the optional FU model responds fu_lat cycles after issue.
  task automatic cycle();
    @(posedge clk);
    #1;
    fu_resp_now = 1'b0;
    if (fu_auto) begin
      fu_out_valid = 1'b0;
      if (fu_cnt > 0) begin
        fu_cnt--;
        if (fu_cnt == 0) begin
          resp_data      = rnd_op();
          resp_vld       = MO'($urandom);
          fu_out_valid   = 1'b1;
          fu_out_inst_id = fu_id;
          fu_out_data    = resp_data;
          fu_out_vld     = resp_vld;
          fu_out_prn     = resp_prn;
          fu_resp_now    = 1'b1;
        end
      end
      if (fu_inst_valid) begin
        fu_cnt   = fu_lat_rand ? int'($urandom_range(1, 4)) : fu_lat;
        fu_id    = fu_inst_id;
        resp_prn = fu_out_prn_o;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; req_valid = '0; wb_ready = 1'b0;
    fu_out_valid = 1'b0; fu_out_inst_id = '0; fu_out_data = '0; fu_out_prn = '0; fu_out_vld = '0;
    fu_auto = 1'b0; fu_lat_rand = 1'b0; fu_lat = 1; fu_cnt = 0;
    for (int r = 0; r < NR; r++) rand_req(r, IB'(r + 1));
    cycle();
    cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    n_checks++; if (fu_inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fu_valid got %b exp 0", fu_inst_valid); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    n_checks++; if ({err_timeout, err_id_mismatch} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b%b exp 00", err_timeout, err_id_mismatch); end
    n_checks++; if ({fu_inst_id, fu_pc, wb_inst_id, wb_data} !== '0) begin n_fail++; $display("FAIL reset_data got nonzero exp 0"); end
    req_valid = 4'b1111; #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_rr_ptr got %b exp 0001", req_ready); end
    req_valid = 4'b0100; #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL grant_single got %b exp 0100", req_ready); end
    flush = 1'b1; #1;
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL flush_idle_ready got %b exp 0", req_ready); end
    flush = 1'b0; req_valid = '0; #1;
  endtask

  task automatic test_single();
    do_reset();
    rand_req(0, 6'd5);
    fu_auto = 1'b1; fu_lat = 3; req_valid = 4'b0001; #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    cycle(); req_valid = '0; #1;
    n_checks++; if (fu_inst_valid !== 1'b1 || fu_inst_id !== 6'd5) begin n_fail++; $display("FAIL single_issue got v=%b id=%0d exp v=1 id=5", fu_inst_valid, fu_inst_id); end
    n_checks++; if ({fu_inst, fu_op, fu_out_prn_o, fu_pc} !== {m_inst[0], m_op[0], m_prn[0], m_pc[0]}) begin n_fail++; $display("FAIL single_fields got inst=%h pc=%h exp inst=%h pc=%h", fu_inst, fu_pc, m_inst[0], m_pc[0]); end
    cycle();
    n_checks++; if (fu_inst_valid !== 1'b0) begin n_fail++; $display("FAIL single_issue_pulse got %b exp 0", fu_inst_valid); end
    cycle(); cycle();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_wb_early got %b exp 0", wb_valid); end
    cycle();
    n_checks++; if (wb_valid !== 1'b1 || wb_inst_id !== 6'd5) begin n_fail++; $display("FAIL single_wb got v=%b id=%0d exp v=1 id=5", wb_valid, wb_inst_id); end
    n_checks++; if ({wb_data, wb_vld, wb_prn} !== {resp_data, resp_vld, m_prn[0]}) begin n_fail++; $display("FAIL single_wb_data got %h exp %h", wb_data, resp_data); end
    wb_ready = 1'b1;
    cycle(); wb_ready = 1'b0; req_valid = 4'b1111; #1;
    n_checks++; if (wb_valid !== 1'b0 || req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_idle got wb=%b ready=%b exp wb=0 ready=0010", wb_valid, req_ready); end
    req_valid = '0; #1;
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int ngrant = 0;
    do_reset();
    for (int r = 0; r < NR; r++) rand_req(r, IB'(10 + r));
    fu_auto = 1'b1; fu_lat = 1; wb_ready = 1'b1; req_valid = 4'b1111; #1;
    for (int c = 0; c < 80 && ngrant < 5; c++) begin
      if (wb_valid && ngrant > 0) begin
        n_checks++; if (wb_inst_id !== IB'(10 + order[ngrant-1])) begin n_fail++; $display("FAIL rr_wb_id got %0d exp %0d", wb_inst_id, 10 + order[ngrant-1]); end
      end
      if (req_ready !== '0) begin
        n_checks++; if (req_ready !== NR'(1 << order[ngrant])) begin n_fail++; $display("FAIL rr_grant%0d got %b exp %0d", ngrant, req_ready, order[ngrant]); end
        ngrant++;
      end
      cycle();
    end
    n_checks++; if (ngrant !== 5) begin n_fail++; $display("FAIL rr_count got %0d exp 5", ngrant); end
    req_valid = '0; wb_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [MO*64-1:0] held;
    do_reset();
    for (int r = 0; r < NR; r++) rand_req(r, IB'(20 + r));
    fu_auto = 1'b1; fu_lat = 2; req_valid = 4'b1111; #1;
    cycle();
    for (int c = 0; c < 20 && !wb_valid; c++) begin
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_wait_ready got %b exp 0", req_ready); end
      cycle();
    end
    n_checks++; if (wb_valid !== 1'b1 || wb_inst_id !== 6'd20 || wb_data !== resp_data) begin n_fail++; $display("FAIL bp_wb got v=%b id=%0d exp v=1 id=20", wb_valid, wb_inst_id); end
    held = resp_data;
    for (int k = 0; k < 10; k++) begin
      n_checks++; if ({wb_valid, wb_data, req_ready} !== {1'b1, held, 4'b0000}) begin n_fail++; $display("FAIL bp_hold%0d got v=%b ready=%b exp v=1 ready=0", k, wb_valid, req_ready); end
      cycle();
    end
    wb_ready = 1'b1; #1;
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_hs_ready got %b exp 0", req_ready); end
    cycle(); wb_ready = 1'b0; #1;
    n_checks++; if (wb_valid !== 1'b0 || req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_resume got wb=%b ready=%b exp wb=0 ready=0010", wb_valid, req_ready); end
    req_valid = '0; #1;
  endtask

  task automatic test_flush();
    do_reset();
    rand_req(0, 6'd3);
    req_valid = 4'b0001; #1;
    cycle(); req_valid = '0;
    cycle(); flush = 1'b1;
    cycle(); flush = 1'b0; req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin fu_out_valid = 1'b1; fu_out_inst_id = 6'd3; fu_out_data = rnd_op(); end
      #1;
      n_checks++; if (req_ready !== '0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drain%0d got ready=%b wb=%b exp 0 0", k, req_ready, wb_valid); end
      cycle();
    end
    fu_out_valid = 1'b0; #1;
    n_checks++; if (req_ready !== 4'b0001 || wb_valid !== 1'b0 || err_id_mismatch !== 1'b0) begin n_fail++; $display("FAIL flush_idle got ready=%b wb=%b mm=%b exp 0001 0 0", req_ready, wb_valid, err_id_mismatch); end
    req_valid = '0; #1;
    cycle(); rand_req(0, 6'd4); req_valid = 4'b0001; #1;
    cycle(); req_valid = '0;
    cycle(); flush = 1'b1; fu_out_valid = 1'b1; fu_out_inst_id = 6'd4;
    cycle(); flush = 1'b0; fu_out_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_concurrent%0d got wb=%b exp 0", k, wb_valid); end
      cycle();
    end
    do_reset();
    fu_auto = 1'b1; fu_lat = 1; req_valid = 4'b0001; #1;
    cycle(); req_valid = '0;
    for (int c = 0; c < 10 && !wb_valid; c++) cycle();
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL flush_hold_setup got wb=%b exp 1", wb_valid); end
    flush = 1'b1; wb_ready = 1'b1;
    cycle(); flush = 1'b0; wb_ready = 1'b0; req_valid = 4'b1111; #1;
    n_checks++; if (wb_valid !== 1'b0 || req_ready !== 4'b0010) begin n_fail++; $display("FAIL flush_hold got wb=%b ready=%b exp 0 0010", wb_valid, req_ready); end
    req_valid = '0; #1;
  endtask

  task automatic test_timeout();
    do_reset();
    rand_req(1, 6'd6); rand_req(2, 6'd7);
    req_valid = 4'b0010; #1;
    cycle(); req_valid = '0;
    for (int k = 1; k <= TO; k++) begin
      n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early%0d got %b exp 0", k, err_timeout); end
      cycle();
    end
    req_valid = 4'b0100; #1;
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag got %b exp 1", err_timeout); end
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL timeout_regrant got %b exp 0100", req_ready); end
    cycle(); req_valid = '0; #1;
    n_checks++; if (fu_inst_valid !== 1'b1 || fu_inst_id !== 6'd7) begin n_fail++; $display("FAIL timeout_issue got v=%b id=%0d exp 1 7", fu_inst_valid, fu_inst_id); end
    for (int k = 0; k < TO + 4; k++) cycle();
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b exp 1", err_timeout); end
    do_reset();
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_rst got %b exp 0", err_timeout); end
  endtask

  task automatic test_id_mismatch();
    do_reset();
    rand_req(0, 6'd5);
    req_valid = 4'b0001; #1;
    cycle(); req_valid = '0;
    cycle(); fu_out_valid = 1'b1; fu_out_inst_id = 6'd9;
    cycle(); fu_out_valid = 1'b0; req_valid = 4'b0001; #1;
    n_checks++; if (err_id_mismatch !== 1'b1 || wb_valid !== 1'b0 || req_ready !== '0) begin n_fail++; $display("FAIL mm_flag got mm=%b wb=%b ready=%b exp 1 0 0", err_id_mismatch, wb_valid, req_ready); end
    cycle(); req_valid = '0;
    resp_data = rnd_op(); fu_out_valid = 1'b1; fu_out_inst_id = 6'd5; fu_out_data = resp_data;
    cycle(); fu_out_valid = 1'b0; #1;
    n_checks++; if (wb_valid !== 1'b1 || wb_inst_id !== 6'd5 || wb_data !== resp_data) begin n_fail++; $display("FAIL mm_accept got v=%b id=%0d exp 1 5", wb_valid, wb_inst_id); end
    rst = 1'b1;
    cycle(); rst = 1'b0; req_valid = 4'b1111; #1;
    n_checks++; if (wb_valid !== 1'b0 || err_id_mismatch !== 1'b0 || req_ready !== 4'b0001) begin n_fail++; $display("FAIL mm_rst_hold got wb=%b mm=%b ready=%b exp 0 0 0001", wb_valid, err_id_mismatch, req_ready); end
    req_valid = '0; fu_out_valid = 1'b1;
    cycle(); fu_out_valid = 1'b0; #1;
    n_checks++; if (err_id_mismatch !== 1'b1) begin n_fail++; $display("FAIL mm_idle_resp got %b exp 1", err_id_mismatch); end
  endtask

  // Transaction-level model: busy from accept to writeback handshake, result buffered once the FU answers.
  task automatic test_random();
    int ptr = 0, txns = 0, g;
    bit busy = 0, got = 0, exp_issue = 0, hs;
    logic [NR-1:0] exp_ready;
    logic [IB-1:0] e_id = '0;
    logic [31:0] e_inst; logic [MO*64-1:0] e_op, e_data; logic [MO*PB-1:0] e_prn; logic [63:0] e_pc; logic [MO-1:0] e_vld;
    do_reset();
    fu_auto = 1'b1; fu_lat_rand = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < NR; r++) rand_req(r, IB'($urandom));
      req_valid = NR'($urandom);
      wb_ready = 1'($urandom_range(0, 1));
      #1;
      exp_ready = '0; g = -1;
      if (!busy) begin
        for (int k = 0; k < NR; k++) if (g < 0 && req_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c=%0d got %b exp %b", c, req_ready, exp_ready); end
      n_checks++; if (fu_inst_valid !== exp_issue) begin n_fail++; $display("FAIL rand_issue c=%0d got %b exp %b", c, fu_inst_valid, exp_issue); end
      if (txns > 0) begin
        n_checks++; if ({fu_inst_id, fu_inst, fu_op, fu_out_prn_o, fu_pc} !== {e_id, e_inst, e_op, e_prn, e_pc}) begin n_fail++; $display("FAIL rand_fu_fields c=%0d got id=%0d exp id=%0d", c, fu_inst_id, e_id); end
      end
      n_checks++; if (wb_valid !== (busy && got)) begin n_fail++; $display("FAIL rand_wb_valid c=%0d got %b exp %b", c, wb_valid, busy && got); end
      if (busy && got) begin
        n_checks++; if ({wb_inst_id, wb_data, wb_vld, wb_prn} !== {e_id, e_data, e_vld, e_prn}) begin n_fail++; $display("FAIL rand_wb_data c=%0d got id=%0d exp id=%0d", c, wb_inst_id, e_id); end
      end
      hs = busy && got && wb_ready;
      if (fu_resp_now && busy && !got) begin got = 1; e_data = resp_data; e_vld = resp_vld; end
      if (hs) begin busy = 0; got = 0; end
      exp_issue = (g >= 0);
      if (g >= 0) begin
        busy = 1; got = 0; txns++;
        e_id = m_id[g]; e_inst = m_inst[g]; e_op = m_op[g]; e_prn = m_prn[g]; e_pc = m_pc[g];
        ptr = (g + 1) % NR;
      end
      cycle();
    end
    n_checks++; if (txns < 20) begin n_fail++; $display("FAIL rand_txn_count got %0d exp >=20", txns); end
    req_valid = '0; wb_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_timeout();
    test_id_mismatch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
